// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush, EX forwarding selects, dmem handshake, stale-fetch discard, event counters.
// Latency: all controls combinational from the current inputs and FSM state; counters update on the next clk edge.
// Backpressure: a pending data access (dmem_ack low) freezes IF..MEM and bubbles WB until the ack arrives.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rs1_addr,
    input  logic [4:0]       ex_rs2_addr,
    input  logic             ex_mm_re,
    input  logic             ex_rd_we,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_redirect,
    input  logic             mem_mm_re,
    input  logic             mem_mm_we,
    input  logic             mem_rd_we,
    input  logic [4:0]       mem_rd_addr,
    input  logic             wb_rd_we,
    input  logic [4:0]       wb_rd_addr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             imem_discard,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_wb,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic MEM_IDLE = 1'b0;
    localparam logic MEM_WAIT = 1'b1;
    localparam logic F_OK     = 1'b0;
    localparam logic F_KILL   = 1'b1;

    logic r_mem_state;
    logic r_fetch_state;
    logic [CNT_W-1:0] r_load_use_cnt;
    logic [CNT_W-1:0] r_mem_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mem_access;
    logic w_mem_stall;
    logic w_load_use;
    logic w_redirect;
    logic w_discard;
    logic w_mem_fwd_ok;
    logic w_wb_fwd_ok;

    // x0 is never a producer, so it is excluded from every match below
    assign w_mem_fwd_ok = mem_rd_we & ~mem_mm_re & (mem_rd_addr != 5'd0);
    assign w_wb_fwd_ok  = wb_rd_we & (wb_rd_addr != 5'd0);

    // EX operand bypass: the younger MEM result beats WB
    always_comb begin
        fwd_rs1_sel = 2'd0;
        fwd_rs2_sel = 2'd0;
        if (w_mem_fwd_ok && mem_rd_addr == ex_rs1_addr)     fwd_rs1_sel = 2'd1;
        else if (w_wb_fwd_ok && wb_rd_addr == ex_rs1_addr)  fwd_rs1_sel = 2'd2;
        if (w_mem_fwd_ok && mem_rd_addr == ex_rs2_addr)     fwd_rs2_sel = 2'd1;
        else if (w_wb_fwd_ok && wb_rd_addr == ex_rs2_addr)  fwd_rs2_sel = 2'd2;
    end

    assign w_mem_access = mem_mm_re | mem_mm_we;
    assign w_mem_stall  = w_mem_access & ~dmem_ack;
    assign dmem_req     = w_mem_access;

    assign w_load_use = ex_mm_re & ex_rd_we & (ex_rd_addr != 5'd0) &
                        ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                         (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

    // A frozen EX re-presents its redirect once the memory wait clears
    assign w_redirect   = ex_redirect & ~w_mem_stall;
    assign w_discard    = (r_fetch_state == F_KILL) & imem_ack;
    assign imem_discard = w_discard;

    // Stall/flush priority: memory wait, then redirect, then load-use, then fetch
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_wb  = 1'b0;
        if (w_mem_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
        end else if (w_redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (w_load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end else if (w_discard) begin
            flush_id = 1'b1;
        end else if (!imem_ack) begin
            stall_if = 1'b1;
            flush_id = 1'b1;
        end
    end

    // Data-memory handshake tracker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_state <= MEM_IDLE;
        end else if (r_mem_state == MEM_IDLE) begin
            if (w_mem_stall) r_mem_state <= MEM_WAIT;
        end else begin
            if (dmem_ack) r_mem_state <= MEM_IDLE;
        end
    end

    // Remember an in-flight fetch that a redirect has killed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_state <= F_OK;
        end else if (w_redirect && (!imem_ack || r_fetch_state == F_KILL)) begin
            r_fetch_state <= F_KILL;
        end else if (w_discard) begin
            r_fetch_state <= F_OK;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load_use_cnt  <= '0;
            r_mem_stall_cnt <= '0;
            r_flush_cnt     <= '0;
        end else begin
            if (w_load_use && !w_mem_stall && !ex_redirect && r_load_use_cnt != '1)
                r_load_use_cnt <= r_load_use_cnt + CNT_W'(1);
            if (w_mem_stall && r_mem_stall_cnt != '1)
                r_mem_stall_cnt <= r_mem_stall_cnt + CNT_W'(1);
            if (w_redirect && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign load_use_cnt  = r_load_use_cnt;
    assign mem_stall_cnt = r_mem_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with narrow counters so saturation is reachable.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Each scenario task checks its own results and bumps the shared counts.
module tb_hazard_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr;
    logic [4:0] ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic id_rs1_used, id_rs2_used, ex_mm_re, ex_rd_we, ex_redirect;
    logic mem_mm_re, mem_mm_we, mem_rd_we, wb_rd_we, imem_ack, dmem_ack;
    logic dmem_req, imem_discard, stall_if, stall_id, stall_ex, stall_mem;
    logic flush_id, flush_ex, flush_wb;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic [CW-1:0] load_use_cnt, mem_stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_mm_re(ex_mm_re), .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr),
        .ex_redirect(ex_redirect),
        .mem_mm_re(mem_mm_re), .mem_mm_we(mem_mm_we),
        .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr),
        .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .imem_discard(imem_discard),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .load_use_cnt(load_use_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rs1_addr = 0; ex_rs2_addr = 0; ex_mm_re = 0; ex_rd_we = 0; ex_rd_addr = 0;
        ex_redirect = 0; mem_mm_re = 0; mem_mm_we = 0; mem_rd_we = 0; mem_rd_addr = 0;
        wb_rd_we = 0; wb_rd_addr = 0; imem_ack = 1; dmem_ack = 0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
    endtask

    // 7-bit control vector: {stall_if,stall_id,stall_ex,stall_mem,flush_id,flush_ex,flush_wb}
    function automatic logic [6:0] ctl();
        return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb};
    endfunction

    task automatic test_reset;
        idle_inputs();
        reset_n = 0;
        #3;
        checks++;
        if (load_use_cnt !== 0 || mem_stall_cnt !== 0 || flush_cnt !== 0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0", load_use_cnt, mem_stall_cnt, flush_cnt);
        end
        checks++;
        if (imem_discard !== 1'b0 || dmem_req !== 1'b0 || ctl() !== 7'b0) begin
            errors++; $display("FAIL reset_out got disc=%b req=%b ctl=%b want 0 0 0000000", imem_discard, dmem_req, ctl());
        end
        tick();
        reset_n = 1;
        #1;
    endtask

    task automatic test_forward;
        do_reset();
        dmem_ack = 1;
        mem_rd_we = 1; mem_rd_addr = 5; wb_rd_we = 1; wb_rd_addr = 5;
        ex_rs1_addr = 5; ex_rs2_addr = 5;
        #1; checks++;
        if (fwd_rs1_sel !== 2'd1 || fwd_rs2_sel !== 2'd1) begin
            errors++; $display("FAIL fwd_mem_prio got %0d/%0d want 1/1", fwd_rs1_sel, fwd_rs2_sel);
        end
        mem_rd_addr = 0;
        #1; checks++;
        if (fwd_rs1_sel !== 2'd2) begin
            errors++; $display("FAIL fwd_mem_x0 got %0d want 2", fwd_rs1_sel);
        end
        mem_rd_addr = 5; mem_mm_re = 1; ex_rs2_addr = 6;
        #1; checks++;
        if (fwd_rs1_sel !== 2'd2 || fwd_rs2_sel !== 2'd0) begin
            errors++; $display("FAIL fwd_load_in_mem got %0d/%0d want 2/0", fwd_rs1_sel, fwd_rs2_sel);
        end
        mem_mm_re = 0; mem_rd_we = 0; wb_rd_addr = 0; ex_rs1_addr = 0;
        #1; checks++;
        if (fwd_rs1_sel !== 2'd0) begin
            errors++; $display("FAIL fwd_wb_x0 got %0d want 0", fwd_rs1_sel);
        end
        tick();
    endtask

    task automatic test_load_use;
        do_reset();
        ex_mm_re = 1; ex_rd_we = 1; ex_rd_addr = 7;
        id_rs2_addr = 7; id_rs2_used = 0; id_rs1_addr = 3; id_rs1_used = 1;
        #1; checks++;
        if (ctl() !== 7'b0) begin
            errors++; $display("FAIL lu_unused_src got ctl=%b want 0000000", ctl());
        end
        id_rs2_used = 1;
        #1; checks++;
        if (ctl() !== 7'b1100010) begin
            errors++; $display("FAIL lu_stall got ctl=%b want 1100010", ctl());
        end
        tick();
        // bubble now in MEM, load in WB, consumer in EX
        ex_mm_re = 0; ex_rd_we = 1; ex_rd_addr = 9; ex_rs2_addr = 7;
        id_rs2_used = 0; wb_rd_we = 1; wb_rd_addr = 7;
        #1; checks++;
        if (fwd_rs2_sel !== 2'd2 || ctl() !== 7'b0) begin
            errors++; $display("FAIL lu_consumer got sel=%0d ctl=%b want 2 0000000", fwd_rs2_sel, ctl());
        end
        checks++;
        if (load_use_cnt !== 1) begin
            errors++; $display("FAIL lu_cnt got %0d want 1", load_use_cnt);
        end
        tick();
    endtask

    task automatic test_mem_wait;
        do_reset();
        mem_mm_we = 1; dmem_ack = 0;
        for (int c = 0; c < 3; c++) begin
            #1; checks++;
            if (dmem_req !== 1'b1 || ctl() !== 7'b1111001) begin
                errors++; $display("FAIL mw_stall%0d got req=%b ctl=%b want 1 1111001", c, dmem_req, ctl());
            end
            tick();
        end
        checks++;
        if (dut.r_mem_state !== 1'b1) begin
            errors++; $display("FAIL mw_state_wait got %b want 1", dut.r_mem_state);
        end
        dmem_ack = 1;
        #1; checks++;
        if (dmem_req !== 1'b1 || ctl() !== 7'b0) begin
            errors++; $display("FAIL mw_ack got req=%b ctl=%b want 1 0000000", dmem_req, ctl());
        end
        tick();
        idle_inputs();
        #1; checks++;
        if (dut.r_mem_state !== 1'b0 || mem_stall_cnt !== 3 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL mw_done got st=%b cnt=%0d req=%b want 0 3 0", dut.r_mem_state, mem_stall_cnt, dmem_req);
        end
    endtask

    task automatic test_redirect;
        do_reset();
        ex_redirect = 1; imem_ack = 0;
        #1; checks++;
        if (ctl() !== 7'b0000110 || imem_discard !== 1'b0) begin
            errors++; $display("FAIL rd_flush got ctl=%b disc=%b want 0000110 0", ctl(), imem_discard);
        end
        tick();
        ex_redirect = 0;
        for (int c = 0; c < 2; c++) begin
            #1; checks++;
            if (ctl() !== 7'b1000100 || imem_discard !== 1'b0) begin
                errors++; $display("FAIL rd_wait%0d got ctl=%b disc=%b want 1000100 0", c, ctl(), imem_discard);
            end
            tick();
        end
        imem_ack = 1;
        #1; checks++;
        if (imem_discard !== 1'b1 || ctl() !== 7'b0000100) begin
            errors++; $display("FAIL rd_discard got disc=%b ctl=%b want 1 0000100", imem_discard, ctl());
        end
        tick();
        #1; checks++;
        if (imem_discard !== 1'b0 || ctl() !== 7'b0 || flush_cnt !== 1) begin
            errors++; $display("FAIL rd_after got disc=%b ctl=%b cnt=%0d want 0 0000000 1", imem_discard, ctl(), flush_cnt);
        end
    endtask

    task automatic test_back_to_back_redirect;
        do_reset();
        ex_redirect = 1; imem_ack = 0;
        tick();
        #1; checks++;
        if (ctl() !== 7'b0000110 || imem_discard !== 1'b0) begin
            errors++; $display("FAIL b2b_second got ctl=%b disc=%b want 0000110 0", ctl(), imem_discard);
        end
        tick();
        ex_redirect = 0; imem_ack = 1;
        #1; checks++;
        if (imem_discard !== 1'b1) begin
            errors++; $display("FAIL b2b_discard got %b want 1", imem_discard);
        end
        tick();
        #1; checks++;
        if (imem_discard !== 1'b0 || flush_cnt !== 2) begin
            errors++; $display("FAIL b2b_after got disc=%b cnt=%0d want 0 2", imem_discard, flush_cnt);
        end
    endtask

    task automatic test_redirect_priority;
        do_reset();
        ex_redirect = 1; imem_ack = 1;
        ex_mm_re = 1; ex_rd_we = 1; ex_rd_addr = 4; id_rs1_addr = 4; id_rs1_used = 1;
        mem_mm_we = 1; dmem_ack = 0;
        for (int c = 0; c < 2; c++) begin
            #1; checks++;
            if (ctl() !== 7'b1111001) begin
                errors++; $display("FAIL pri_stall%0d got ctl=%b want 1111001", c, ctl());
            end
            tick();
        end
        dmem_ack = 1;
        #1; checks++;
        if (ctl() !== 7'b0000110) begin
            errors++; $display("FAIL pri_redirect got ctl=%b want 0000110", ctl());
        end
        tick();
        idle_inputs();
        #1; checks++;
        if (flush_cnt !== 1 || load_use_cnt !== 0 || mem_stall_cnt !== 2) begin
            errors++; $display("FAIL pri_cnt got %0d/%0d/%0d want 1/0/2", flush_cnt, load_use_cnt, mem_stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        mem_mm_re = 1; dmem_ack = 0;
        tick();
        tick();
        checks++;
        if (dut.r_mem_state !== 1'b1 || mem_stall_cnt !== 2) begin
            errors++; $display("FAIL rst_pre got st=%b cnt=%0d want 1 2", dut.r_mem_state, mem_stall_cnt);
        end
        #2;
        reset_n = 0;
        #1; checks++;
        if (dut.r_mem_state !== 1'b0 || mem_stall_cnt !== 0 || dmem_req !== 1'b1) begin
            errors++; $display("FAIL rst_async got st=%b cnt=%0d req=%b want 0 0 1", dut.r_mem_state, mem_stall_cnt, dmem_req);
        end
        idle_inputs();
        tick();
        reset_n = 1;
        #1;
    endtask

    task automatic test_saturate;
        do_reset();
        ex_redirect = 1; imem_ack = 1;
        for (int c = 0; c < 15; c++) tick();
        checks++;
        if (flush_cnt !== 4'hF) begin
            errors++; $display("FAIL sat_reach got %0d want 15", flush_cnt);
        end
        tick();
        checks++;
        if (flush_cnt !== 4'hF) begin
            errors++; $display("FAIL sat_hold got %0d want 15", flush_cnt);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_back_to_back_redirect();
        test_redirect_priority();
        test_reset_mid_wait();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
